sram10t_port_ctrl: RTL
======================

Name: sram10t_port_ctrl

Overview:
- Controller/arbiter in front of the SRAM10T macro: 4096 x 1-bit cells, two read address ports, one shared write path, DevEn/RdWr control.
- Shares the macro between two read requesters (rd0, rd1) and one write requester (wr).
- Sequences every access through a fixed-latency FSM and returns read data with a valid pulse.
- All macro control/address/data pins are driven from registers so the macro sees glitch-free inputs.

Parameters:
ADDR_W, 12, macro address width (4096 cells)
RD_LAT, 1, cycles after the issue cycle before readLine1/readLine2 are sampled; legal range 1..7

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  synchronous, active-high reset
rd0_req  in  1  read request, held until rd0_gnt
rd0_addr  in  ADDR_W  read address, stable while rd0_req=1
rd0_gnt  out  1  one-cycle pulse: request accepted, address latched
rd0_vld  out  1  one-cycle pulse: rd0_data valid
rd0_data  out  1  read bit
rd1_req/rd1_addr/rd1_gnt/rd1_vld/rd1_data  same as rd0, served on macro port 2
wr_req  in  1  write request, held until wr_gnt
wr_addr  in  ADDR_W  write address
wr_data  in  1  write bit
wr_gnt  out  1  one-cycle pulse: write accepted
wr_done  out  1  one-cycle pulse: write committed
busy  out  1  1 whenever FSM not in IDLE
sram_en  out  1  to DevEn
sram_rdwr  out  1  to RdWr; 1=read, 0=write
sram_addr1  out  ADDR_W  to addr1 (rd0 address, or write address)
sram_addr2  out  ADDR_W  to addr2 (rd1 address)
sram_wdata  out  1  to writeLine
sram_rd1  in  1  from readLine1
sram_rd2  in  1  from readLine2

Behaviour:
- Reset values: every output 0 except sram_rdwr=1. FSM=IDLE, priority flag=WRITE_FIRST, delay counter=0.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_DONE.
- IDLE, arbitration on the current cycle's requests:
  - Only reads pending: grant every pending read together. Pulse rdX_gnt this cycle, latch addresses and the granted-port mask, go to RD_ISSUE.
  - Only wr pending: pulse wr_gnt, latch wr_addr/wr_data, go to WR_ISSUE.
  - Reads and write both pending: prio flag selects the class. Flag toggles after each contested grant, so contested service strictly alternates. First contested grant after reset goes to the write.
  - Nothing pending: stay in IDLE with sram_en=0.
- RD_ISSUE (1 cycle):
  - sram_en=1, sram_rdwr=1.
  - sram_addr1 = latched rd0 addr if granted, else holds its previous value.
  - sram_addr2 likewise for rd1.
  - Load delay counter with RD_LAT, go to RD_WAIT.
- RD_WAIT:
  - sram_en=0, counter decrements each cycle.
  - When counter reaches 1: register sram_rd1 into rd0_data and sram_rd2 into rd1_data for granted ports only; pulse their vld next cycle. Go to IDLE.
  - Total req-to-vld latency for an uncontested read = RD_LAT+2 cycles after gnt.
- WR_ISSUE (1 cycle): sram_en=1, sram_rdwr=0, sram_addr1=wr addr, sram_wdata=wr data. Go to WR_DONE.
- WR_DONE (1 cycle): sram_en=0, sram_rdwr=1, wr_done pulses. Go to IDLE.
- Ungranted read port never pulses vld. Its rdX_data holds the last value.
- rd0 and rd1 at the same address in one grant is legal; both return the same bit.
- Read-after-write to the same address is serialized by the FSM, so a later read always returns the committed value.
- Addresses pass through unmodified. 4095 is a legal address; there is no wrap and no arithmetic on addresses.
- Requests dropped before gnt are ignored. A request may be re-asserted the cycle after its gnt and is arbitrated in the next IDLE.
- sram_en is never high two consecutive cycles. sram_rdwr is 0 only during WR_ISSUE.
- rst mid-operation: back to IDLE next edge with reset values. The in-flight op is aborted: no vld and no wr_done for it. A write aborted after WR_ISSUE may or may not be committed in the macro; the requester must retry.

Decomposition:
- Package sram10t_ctrl_pkg holds:
  - state enum
  - RDWR_READ=1, RDWR_WRITE=0
  - default ADDR_W and RD_LAT
- One natural sub-module, sram10t_req_arb:
  - combinational class select plus the priority-flag register
  - inputs: req vector; outputs: gnt vector
  - reused by the future bank-interleaved controller.

Test Plan:
- rd0_req addr=0x07B, cell=1 -> rd0_gnt next-edge pulse. sram_en=1/sram_rdwr=1/sram_addr1=0x07B one cycle later. rd0_vld=1, rd0_data=1 at gnt+RD_LAT+2. rd1_vld stays 0.
- rd0 addr=0x000 and rd1 addr=0xFFF in the same cycle -> single RD_ISSUE with addr1=0x000, addr2=0xFFF. Both vld pulse in the same cycle with the correct bits.
- wr addr=0x07B data=0, then rd0 addr=0x07B -> WR_ISSUE with sram_rdwr=0, sram_wdata=0. wr_done one cycle later. Read returns 0.
- wr and rd0 both held continuously for 6 grants -> grant order wr, rd, wr, rd, wr, rd. sram_en never high on back-to-back cycles.
- rst=1 during RD_WAIT (RD_LAT=3) -> next cycle: busy=0, sram_en=0, sram_rdwr=1, no rd0_vld for the aborted read. A new request after rst is served normally.
- Idle with no requests for 20 cycles -> sram_en=0, busy=0, every gnt/vld/done stays 0.

Source files
------------

// File: rtl/sram10t_ctrl_pkg.sv
// Shared types and constants for the SRAM10T port controller and its arbiter.
package sram10t_ctrl_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_RD_LAT = 1;

  localparam logic RDWR_READ  = 1'b1;
  localparam logic RDWR_WRITE = 1'b0;

  // Bit positions of the request classes in the arbiter req/gnt vectors
  localparam int CLS_RD = 0;
  localparam int CLS_WR = 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    WR_DONE
  } state_t;

  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } prio_t;

endpackage

// File: rtl/sram10t_req_arb.sv
// Read-class vs write-class arbiter; contested grants strictly alternate,
// uncontested requests are granted directly.
module sram10t_req_arb
  import sram10t_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  prio_t prio_q;
  logic  contested;

  assign contested = req[CLS_RD] & req[CLS_WR];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/case can leave it unassigned and infer a latch.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (contested) begin
        gnt[CLS_WR] = (prio_q == WRITE_FIRST);
        gnt[CLS_RD] = (prio_q == READ_FIRST);
      end else begin
        gnt = req;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= WRITE_FIRST;
    end else if (en && contested) begin
      prio_q <= (prio_q == WRITE_FIRST) ? READ_FIRST : WRITE_FIRST;
    end
  end

endmodule

// File: rtl/sram10t_port_ctrl.sv
// Two-reader / one-writer controller for the SRAM10T macro; every macro pin
// comes straight from a flop and every access takes a fixed number of cycles.
module sram10t_port_ctrl
  import sram10t_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd0_req,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic              rd0_gnt,
  output logic              rd0_vld,
  output logic              rd0_data,
  input  logic              rd1_req,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd1_gnt,
  output logic              rd1_vld,
  output logic              rd1_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  output logic              wr_gnt,
  output logic              wr_done,
  output logic              busy,
  output logic              sram_en,
  output logic              sram_rdwr,
  output logic [ADDR_W-1:0] sram_addr1,
  output logic [ADDR_W-1:0] sram_addr2,
  output logic              sram_wdata,
  input  logic              sram_rd1,
  input  logic              sram_rd2
);

  state_t            state_q, state_d;
  logic [1:0]        arb_gnt;
  logic [1:0]        rd_mask_q;   // {rd1 granted, rd0 granted}
  logic [1:0]        vld_pend_q;
  logic [ADDR_W-1:0] rd0_addr_q, rd1_addr_q, wr_addr_q;
  logic              wr_data_q;
  logic [2:0]        cnt_q;
  logic              idle;

  assign idle = (state_q == IDLE);
  assign busy = ~idle;

  sram10t_req_arb u_arb (
    .clk (clk),
    .rst (rst),
    .en  (idle),
    .req ({wr_req, rd0_req | rd1_req}),
    .gnt (arb_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (arb_gnt[CLS_WR])      state_d = WR_ISSUE;
        else if (arb_gnt[CLS_RD]) state_d = RD_ISSUE;
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  if (cnt_q == 3'd1) state_d = IDLE;
      WR_ISSUE: state_d = WR_DONE;
      WR_DONE:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Registered outputs and datapath; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd0_gnt    <= 1'b0;
      rd1_gnt    <= 1'b0;
      wr_gnt     <= 1'b0;
      rd0_vld    <= 1'b0;
      rd1_vld    <= 1'b0;
      wr_done    <= 1'b0;
      rd0_data   <= 1'b0;
      rd1_data   <= 1'b0;
      sram_en    <= 1'b0;
      sram_rdwr  <= RDWR_READ;
      sram_addr1 <= '0;
      sram_addr2 <= '0;
      sram_wdata <= 1'b0;
      rd_mask_q  <= 2'b00;
      vld_pend_q <= 2'b00;
      rd0_addr_q <= '0;
      rd1_addr_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= 1'b0;
      cnt_q      <= 3'd0;
    end else begin
      rd0_gnt    <= 1'b0;
      rd1_gnt    <= 1'b0;
      wr_gnt     <= 1'b0;
      wr_done    <= 1'b0;
      sram_en    <= 1'b0;
      vld_pend_q <= 2'b00;
      rd0_vld    <= vld_pend_q[0];
      rd1_vld    <= vld_pend_q[1];
      case (state_q)
        IDLE: begin
          if (arb_gnt[CLS_WR]) begin
            wr_gnt    <= 1'b1;
            wr_addr_q <= wr_addr;
            wr_data_q <= wr_data;
          end else if (arb_gnt[CLS_RD]) begin
            rd0_gnt    <= rd0_req;
            rd1_gnt    <= rd1_req;
            rd_mask_q  <= {rd1_req, rd0_req};
            rd0_addr_q <= rd0_addr;
            rd1_addr_q <= rd1_addr;
          end
        end
        RD_ISSUE: begin
          sram_en   <= 1'b1;
          sram_rdwr <= RDWR_READ;
          if (rd_mask_q[0]) sram_addr1 <= rd0_addr_q;
          if (rd_mask_q[1]) sram_addr2 <= rd1_addr_q;
          cnt_q <= 3'(RD_LAT);
        end
        RD_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            if (rd_mask_q[0]) rd0_data <= sram_rd1;
            if (rd_mask_q[1]) rd1_data <= sram_rd2;
            vld_pend_q <= rd_mask_q;
          end
        end
        WR_ISSUE: begin
          sram_en    <= 1'b1;
          sram_rdwr  <= RDWR_WRITE;
          sram_addr1 <= wr_addr_q;
          sram_wdata <= wr_data_q;
        end
        WR_DONE: begin
          sram_rdwr <= RDWR_READ;
          wr_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
